vga_char_render: RTL

//  Consumer end of the display-component interface: takes the char/nibble, colour, zoom and h2a

---
 rtl/vga_char_render.sv | 117 +++++++++++
 1 files changed

// File: rtl/vga_char_render.sv
// Character renderer: converts component char/colour/zoom into pixels via the 8x8 font ROM.
// Three-stage pipeline with hsync/vsync/activevideo delayed to stay aligned with the output rgb.
module vga_char_render #(
  parameter logic [2:0] BG        = 3'b000,
  parameter int         BLINK_LOG = 5
) (
  input  logic       i_px_clk,
  input  logic       i_reset,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_activevideo,
  input  logic       i_hsync_in,
  input  logic       i_vsync_in,
  input  logic [7:0] i_char_in,
  input  logic [2:0] i_color_in,
  input  logic [1:0] i_zoom_in,
  input  logic       i_h2a_in,
  output logic [9:0] o_font_addr,
  input  logic [7:0] i_font_data,
  output logic [2:0] o_rgb,
  output logic       o_hsync,
  output logic       o_vsync
);

  localparam logic [2:0] BLACK = 3'b000;

  logic [9:0]         r_x_d1;
  logic [9:0]         r_y_d1;
  logic               r_act_d1, r_act_d2;
  logic               r_hs_d1, r_hs_d2, r_hs_d3;
  logic               r_vs_d1, r_vs_d2, r_vs_d3;
  logic [9:0]         r_font_addr;
  logic [2:0]         r_col;
  logic [2:0]         r_color;
  logic               r_blink;
  logic               r_draw;
  logic [2:0]         r_rgb;
  logic [BLINK_LOG:0] r_frame;

  logic [1:0] w_zoom;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_bit;
  logic       w_phase;
  logic       w_vs_fall;

  // Zoom 3 is clamped to 2; shifting then taking 3 bits equals a variable part-select.
  assign w_zoom  = (i_zoom_in == 2'd3) ? 2'd2 : i_zoom_in;
  assign w_nib   = i_char_in[3:0];
  assign w_glyph = i_h2a_in ? ((w_nib < 4'd10) ? (7'h30 + {3'b000, w_nib})
                                               : (7'h37 + {3'b000, w_nib}))
                            : i_char_in[6:0];
  assign w_row   = r_y_d1[w_zoom +: 3];
  assign w_col   = r_x_d1[w_zoom +: 3];

  assign w_bit     = i_font_data[3'd7 - r_col];
  assign w_phase   = r_frame[BLINK_LOG];
  // r_vs_d1 holds last cycle's vsync_in, so this marks the falling edge.
  assign w_vs_fall = r_vs_d1 & ~i_vsync_in;

  always_ff @(posedge i_px_clk) begin
    if (i_reset) begin
      r_x_d1      <= '0;
      r_y_d1      <= '0;
      r_act_d1    <= 1'b0;
      r_act_d2    <= 1'b0;
      r_hs_d1     <= 1'b1;
      r_hs_d2     <= 1'b1;
      r_hs_d3     <= 1'b1;
      r_vs_d1     <= 1'b1;
      r_vs_d2     <= 1'b1;
      r_vs_d3     <= 1'b1;
      r_font_addr <= '0;
      r_col       <= '0;
      r_color     <= '0;
      r_blink     <= 1'b0;
      r_draw      <= 1'b0;
      r_rgb       <= 3'b000;
      r_frame     <= '0;
    end else begin
      r_x_d1   <= i_x;
      r_y_d1   <= i_y;
      r_act_d1 <= i_activevideo;
      r_act_d2 <= r_act_d1;
      r_hs_d1  <= i_hsync_in;
      r_hs_d2  <= r_hs_d1;
      r_hs_d3  <= r_hs_d2;
      r_vs_d1  <= i_vsync_in;
      r_vs_d2  <= r_vs_d1;
      r_vs_d3  <= r_vs_d2;

      r_font_addr <= {w_glyph, w_row};
      r_col       <= w_col;
      r_color     <= i_color_in;
      r_blink     <= i_char_in[7] & ~i_h2a_in;
      r_draw      <= (i_color_in != BLACK);

      if (!r_act_d2)
        r_rgb <= 3'b000;
      else if (r_draw && w_bit && !(r_blink && w_phase))
        r_rgb <= r_color;
      else
        r_rgb <= BG;

      if (w_vs_fall)
        r_frame <= r_frame + {{BLINK_LOG{1'b0}}, 1'b1};
    end
  end

  assign o_font_addr = r_font_addr;
  assign o_rgb       = r_rgb;
  assign o_hsync     = r_hs_d3;
  assign o_vsync     = r_vs_d3;

endmodule
